fft_result_reader: RTL and testbench

// - Unload engine for fft_ram: after the FFT finishes, reads all NUM_POINTS complex results and streams them out as words.
// - Reads in bit-reversed index order, so the output comes out in natural frequency order.
// - Sends real then imag for each point over a valid/ready word stream.
// - Sits beside the external loader on the fft_ram scan port (indexA mux); it is the read-side counterpart of the load path.

---
 rtl/fft_pkg.sv | 30 +++
 rtl/fft_out_fifo.sv | 39 +++
 rtl/fft_result_reader.sv | 133 +++++++++++++
 tb/tb_fft_result_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, complex word type and the bit-reversal helper.
package fft_pkg;

   localparam int unsigned NUM_POINTS = 1024;
   localparam int unsigned ADDR_W     = 10;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CNT_W      = ADDR_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_DONE
   } rd_state_t;

   // Mirror the index bits: MSB <-> LSB.
   function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] r;
      for (int i = 0; i < int'(ADDR_W); i++) begin
         r[i] = a[ADDR_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_out_fifo.sv
// Two-entry complex FIFO between the RAM read port and the word serialiser.
module fft_out_fifo
   import fft_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  cplx_t      push_data,
   input  logic       pop,
   output cplx_t      head,
   output logic [1:0] count
);

   cplx_t mem [2];
   logic  wr_ptr;
   logic  rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fft_result_reader.sv
// Unloads fft_ram in bit-reversed index order and streams real/imag words.
module fft_result_reader
   import fft_pkg::*;
#(
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              scan,
   output logic [ADDR_W-1:0] scanIndex,
   input  logic [DATA_W-1:0] ramReal_i,
   input  logic [DATA_W-1:0] ramImag_i,
   output logic [DATA_W-1:0] outData,
   output logic              outValid,
   input  logic              outReady,
   output logic              outLast
);

   rd_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  pop_cnt_q;
   logic              in_flight_q;
   logic              phase_q;
   logic              issue;
   logic [ADDR_W-1:0] issue_idx;
   logic [ADDR_W-1:0] rd_addr;
   logic              credit_ok;
   logic              hs;
   logic              pop;
   logic              last_point;
   logic [1:0]        fifo_count;
   logic [1:0]        count_next;
   cplx_t             fifo_head;
   cplx_t             push_data;

   assign push_data.re = ramReal_i;
   assign push_data.im = ramImag_i;

   fft_out_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_flight_q),
      .push_data (push_data),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign outValid   = (fifo_count != 2'd0);
   assign hs         = outValid && outReady;
   assign pop        = hs && phase_q;
   assign last_point = (pop_cnt_q == CNT_W'(NUM_POINTS - 1));
   assign outData    = outValid ? (phase_q ? fifo_head.im : fifo_head.re) : '0;
   assign outLast    = outValid && phase_q && last_point;

   // scan is registered, so the credit test looks at next-cycle occupancy.
   assign count_next = fifo_count + 2'(in_flight_q) - 2'(pop);
   assign credit_ok  = (3'(count_next) + 3'(scan)) < 3'd2;
   assign rd_addr    = BIT_REVERSE ? bit_reverse(issue_idx) : issue_idx;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      issue     = 1'b0;
      issue_idx = cnt_q[ADDR_W-1:0];
      case (state_q)
         ST_IDLE: begin
            cnt_d     = '0;
            issue_idx = '0;
            if (start) begin
               state_d = ST_READ;
               issue   = 1'b1;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_READ: begin
            if (cnt_q == CNT_W'(NUM_POINTS)) begin
               state_d = ST_DRAIN;
            end else if (credit_ok) begin
               issue = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (pop && last_point) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pop_cnt_q   <= '0;
         in_flight_q <= 1'b0;
         phase_q     <= 1'b0;
         scan        <= 1'b0;
         scanIndex   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         scan        <= issue;
         in_flight_q <= scan;
         if (issue) begin
            scanIndex <= rd_addr;
         end
         if (hs) begin
            phase_q <= ~phase_q;
         end
         if (state_q == ST_IDLE) begin
            pop_cnt_q <= '0;
         end else if (pop) begin
            pop_cnt_q <= pop_cnt_q + CNT_W'(1);
         end
         busy <= (state_d == ST_READ) || (state_d == ST_DRAIN);
         done <= (state_d == ST_DONE);
      end
   end

endmodule

// File: tb/tb_fft_result_reader.sv
// Bench for fft_result_reader: stream-level reference model, random backpressure.
module tb_fft_result_reader;

   localparam int N  = 1024;
   localparam int W  = 2 * N;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, out_ready, sel;
   logic start0, start1;
   assign start0 = start & ~sel;
   assign start1 = start & sel;

   logic          busy0, done0, scan0, valid0, last0;
   logic [AW-1:0] idx0;
   logic [DW-1:0] data0, rre0, rim0;
   logic          busy1, done1, scan1, valid1, last1;
   logic [AW-1:0] idx1;
   logic [DW-1:0] data1, rre1, rim1;

   logic [DW-1:0] mem_re [N];
   logic [DW-1:0] mem_im [N];

   fft_result_reader #(.BIT_REVERSE(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
      .scan(scan0), .scanIndex(idx0), .ramReal_i(rre0), .ramImag_i(rim0),
      .outData(data0), .outValid(valid0), .outReady(out_ready), .outLast(last0)
   );

   fft_result_reader #(.BIT_REVERSE(1'b0)) dut_nat (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .scan(scan1), .scanIndex(idx1), .ramReal_i(rre1), .ramImag_i(rim1),
      .outData(data1), .outValid(valid1), .outReady(out_ready), .outLast(last1)
   );

   // fft_ram model: registered read, data one cycle after the index.
   always @(posedge clk) begin
      rre0 <= mem_re[idx0];
      rim0 <= mem_im[idx0];
      rre1 <= mem_re[idx1];
      rim1 <= mem_im[idx1];
   end

   logic          m_busy, m_done, m_scan, m_valid, m_last;
   logic [AW-1:0] m_idx;
   logic [DW-1:0] m_data;
   assign m_busy  = sel ? busy1  : busy0;
   assign m_done  = sel ? done1  : done0;
   assign m_scan  = sel ? scan1  : scan0;
   assign m_valid = sel ? valid1 : valid0;
   assign m_last  = sel ? last1  : last0;
   assign m_idx   = sel ? idx1   : idx0;
   assign m_data  = sel ? data1  : data0;

   int          n_checks;
   int          n_pass;
   int          issued;
   int          popped;
   int          word_n;
   bit          hold_pending;
   bit          done_due;
   logic [33:0] hold_val;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s got=%0h want=%0h", tag, got, want);
   endtask

   function automatic int bitrev_ref(input int k);
      int r = 0;
      for (int i = 0; i < AW; i++) r = r * 2 + ((k >> i) & 1);
      return r;
   endfunction

   function automatic int exp_addr(input int i);
      return sel ? i : bitrev_ref(i);
   endfunction

   function automatic logic [DW-1:0] exp_word(input int n);
      int a = exp_addr(n / 2);
      return (n % 2 == 1) ? mem_im[a] : mem_re[a];
   endfunction

   task automatic ramp_fill();
      for (int i = 0; i < N; i++) begin
         mem_re[i] = 32'(i);
         mem_im[i] = ~32'(i);
      end
   endtask

   task automatic random_fill();
      for (int i = 0; i < N; i++) begin
         mem_re[i] = $urandom;
         mem_im[i] = $urandom;
      end
   endtask

   task automatic begin_frame();
      issued       = 0;
      popped       = 0;
      word_n       = 0;
      hold_pending = 1'b0;
      done_due     = 1'b0;
   endtask

   // Observe one cycle just before its rising edge.
   task automatic monitor();
      bit exp_done;
      exp_done = done_due;
      done_due = 1'b0;
      if (m_done || exp_done) check("done", 64'(m_done), 64'(exp_done));
      if (m_scan) begin
         check("credit", 64'((issued - popped) < 2), 64'd1);
         if (issued < N) check("scan_idx", 64'(m_idx), 64'(exp_addr(issued)));
         else check("extra_read", 64'd0, 64'd1);
         issued++;
      end
      if (hold_pending) check("hold", 64'({m_valid, m_last, m_data}), 64'(hold_val));
      hold_pending = 1'b0;
      if (m_valid && out_ready) begin
         if (word_n < W) begin
            check("word", 64'(m_data), 64'(exp_word(word_n)));
            check("last", 64'(m_last), 64'(word_n == W - 1));
         end else begin
            check("extra_word", 64'd0, 64'd1);
         end
         if (word_n % 2 == 1) popped++;
         if (word_n == W - 1) done_due = 1'b1;
         word_n++;
      end else if (m_valid) begin
         hold_pending = 1'b1;
         hold_val     = {1'b1, m_last, m_data};
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_frame(input int pct, input int stop, input int start_word);
      int budget = 0;
      bit sent   = 1'b0;
      while (word_n < stop && budget < 20000) begin
         out_ready = ($urandom_range(0, 99) < pct);
         start     = !sent && (start_word >= 0) && (word_n == start_word);
         if (start) sent = 1'b1;
         tick();
         budget++;
      end
      start = 1'b0;
      if (word_n < stop) check("timeout", 64'(word_n), 64'(stop));
   endtask

   task automatic finish_frame();
      repeat (3) tick();
      check("reads", 64'(issued), 64'(N));
      check("idle_busy", 64'(m_busy), 64'd0);
      check("idle_valid", 64'(m_valid), 64'd0);
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      sel       = 1'b0;
      ramp_fill();
      begin_frame();
      repeat (3) tick();
      check("reset0", 64'({busy0, done0, scan0, idx0, valid0, data0, last0}), 64'd0);
      check("reset1", 64'({busy1, done1, scan1, idx1, valid1, data1, last1}), 64'd0);
      rst = 1'b0;
      tick();

      // Ramp, full throughput, with latency checks.
      out_ready = 1'b1;
      pulse_start();
      check("lat_busy", 64'(busy0), 64'd1);
      check("lat_scan", 64'(scan0), 64'd1);
      check("lat_valid_k1", 64'(valid0), 64'd0);
      tick();
      check("lat_valid_k2", 64'(valid0), 64'd0);
      tick();
      check("lat_valid", 64'(valid0), 64'd1);
      check("first_word", 64'(data0), 64'(exp_word(0)));
      run_frame(100, W, -1);
      finish_frame();

      // Random data, 30% ready.
      random_fill();
      begin_frame();
      pulse_start();
      run_frame(30, W, -1);
      finish_frame();

      // Long stall right after start.
      ramp_fill();
      begin_frame();
      out_ready = 1'b0;
      pulse_start();
      repeat (100) tick();
      check("stall_reads", 64'(issued), 64'd2);
      check("stall_scan", 64'(m_scan), 64'd0);
      check("stall_valid", 64'(m_valid), 64'd1);
      check("stall_data", 64'(m_data), 64'(exp_word(0)));
      run_frame(100, W, -1);
      finish_frame();

      // Start mid-frame and in the done cycle are ignored; the next cycle restarts.
      begin_frame();
      pulse_start();
      run_frame(70, W, 500);
      start = 1'b1;
      tick();
      check("done_start_ignored", 64'(m_busy), 64'd0);
      begin_frame();
      tick();
      start = 1'b0;
      check("restart_busy", 64'(m_busy), 64'd1);
      run_frame(100, W, -1);
      finish_frame();

      // Asynchronous reset mid-frame.
      begin_frame();
      pulse_start();
      run_frame(100, 700, -1);
      rst = 1'b1;
      #1;
      check("async_rst", 64'({busy0, done0, scan0, idx0, valid0, data0, last0}), 64'd0);
      begin_frame();
      repeat (2) tick();
      rst = 1'b0;
      tick();
      pulse_start();
      run_frame(100, W, -1);
      finish_frame();

      // Natural-order instance.
      sel = 1'b1;
      ramp_fill();
      begin_frame();
      pulse_start();
      run_frame(100, W, -1);
      finish_frame();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
